// File: rtl/mem_ctrl_pipe_pkg.sv
// mem_ctrl_pkg: shared FSM states, response record and address range check for mem_ctrl_pipe
package mem_ctrl_pkg;
  localparam int RSP_DW = 32;
  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic [RSP_DW-1:0] rdata;
    logic              is_wr;
    logic              err;
  } rsp_t;
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/mem_ctrl_pipe_if.sv
// mem_ctrl_pipe_if: request/response channel bundle between a bus master and mem_ctrl_pipe
interface mem_ctrl_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_is_wr;
  logic                    rsp_err;
  logic                    init_done;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_is_wr, rsp_err, init_done
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_is_wr, rsp_err, init_done
  );
endinterface

// File: rtl/mem_ctrl_pipe_rsp_fifo.sv
// mem_rsp_fifo: circular response FIFO with occupancy count; overflow is a design error
module mem_rsp_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  rsp_t                       data_i,
  input  logic                       pop_i,
  output rsp_t                       data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  rsp_t          mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_pop;
  assign do_pop  = pop_i && count_q != '0;
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1);
      if (do_pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  ovf_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(push_i && !do_pop && count_q == CW'(DEPTH)));
endmodule

// File: rtl/mem_ctrl_pipe.sv
// mem_ctrl_pipe: byte-enable RAM with fixed-latency pipe and in-order response FIFO;
// defining MEM_INIT_CLEAR_EN adds a post-reset zero sweep of the whole array.
module mem_ctrl_pipe
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int MEM_DEPTH    = 256,
  parameter int READ_LATENCY = 2,
  parameter int RSP_DEPTH    = 4
) (
  input logic            clk,
  input logic            reset_n,
  mem_ctrl_pipe_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                  pipe_v_q [READ_LATENCY];
  rsp_t                  pipe_q [READ_LATENCY];
  logic [CW-1:0]         inflight_q, inflight_d, fifo_cnt;
  rsp_t                  req_rsp, fifo_head;
  logic                  fire, hit, pipe_out;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] rd_data;
  assign idx      = IW'(bus.req_addr);
  assign hit      = in_range(32'(bus.req_addr), MEM_DEPTH);
  assign rd_data  = (hit && !bus.req_we) ? mem_q[idx] : '0;
  assign req_rsp  = '{rdata: RSP_DW'(rd_data), is_wr: bus.req_we, err: !hit};
  // credits cover both the pipe and the FIFO, so the FIFO can never overflow
  assign bus.req_ready = state_q == RUN && (32'(inflight_q) + 32'(fifo_cnt)) < 32'(RSP_DEPTH);
  assign fire       = bus.req_valid && bus.req_ready;
  assign pipe_out   = pipe_v_q[READ_LATENCY-1];
  assign inflight_d = inflight_q + CW'(fire) - CW'(pipe_out);
  assign bus.init_done = state_q == RUN;
  assign bus.rsp_valid = fifo_cnt != '0;
  assign bus.rsp_rdata = bus.rsp_valid ? DATA_WIDTH'(fifo_head.rdata) : '0;
  assign bus.rsp_is_wr = bus.rsp_valid && fifo_head.is_wr;
  assign bus.rsp_err   = bus.rsp_valid && fifo_head.err;
`ifdef MEM_INIT_CLEAR_EN
  localparam int SW = $clog2(MEM_DEPTH + 1);
  logic [SW-1:0] clr_q;
  logic          clr_last;
  assign clr_last = clr_q == SW'(MEM_DEPTH);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clr_q <= '0;
    else if (state_q == INIT && !clr_last) clr_q <= clr_q + SW'(1);
  end
  always_comb begin
    state_d = state_q;
    state_d = (state_q == INIT && clr_last) ? RUN : state_q;
  end
`else
  always_comb begin
    state_d = state_q;
    state_d = RUN;
  end
`endif
  always_ff @(posedge clk) begin
`ifdef MEM_INIT_CLEAR_EN
    if (state_q == INIT && !clr_last) mem_q[IW'(clr_q)] <= '0;
`endif
    if (fire && bus.req_we && hit)
      for (int b = 0; b < NB; b++)
        if (bus.req_be[b]) mem_q[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_q[i]   <= '0;
      end
      inflight_q <= '0;
      state_q    <= INIT;
    end else begin
      pipe_v_q[0] <= fire;
      pipe_q[0]   <= req_rsp;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_q[i]   <= pipe_q[i-1];
      end
      inflight_q <= inflight_d;
      state_q    <= state_d;
    end
  end
  mem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (pipe_out),
    .data_i  (pipe_q[READ_LATENCY-1]),
    .pop_i   (bus.rsp_valid && bus.rsp_ready),
    .data_o  (fifo_head),
    .count_o (fifo_cnt)
  );
endmodule

// File: tb/tb_mem_ctrl_pipe.sv
// tb_mem_ctrl_pipe: directed stimulus with a response scoreboard for mem_ctrl_pipe
module tb_mem_ctrl_pipe;
  localparam int DW = 32, AW = 8, DEPTH = 200, LAT = 2, RD = 4;
`ifdef MEM_INIT_CLEAR_EN
  localparam int EXP_INIT = DEPTH + 1;
`else
  localparam int EXP_INIT = 1;
`endif
  typedef struct {
    logic [31:0] rdata;
    logic        is_wr;
    logic        err;
    logic        lat;
    int          fcyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0, n_pass = 0, cyc = 0, stalls = 0, rsp_n = 0;
  logic lat_on;
  exp_t exp_q[$];
  exp_t mon_e;
  logic stalled = 1'b0;
  logic [33:0] held;
  logic [31:0] tbl [4] = '{32'hA5A5_0001, 32'h0BAD_F00D, 32'h1357_9BDF, 32'h8000_0001};
  mem_ctrl_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  mem_ctrl_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .READ_LATENCY(LAT), .RSP_DEPTH(RD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask
  // monitor: pops the scoreboard on every response handshake
  always begin
    @(negedge clk);
    #2;
    if (reset_n) begin
      if (stalled)
        chk("rsp_hold", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_is_wr, bus.rsp_err}, {1'b1, held});
      if (!bus.rsp_valid) chk("idle_rdata", bus.rsp_rdata, 0);
      else if (bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", {1'b1, bus.rsp_rdata}, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("rsp%0d", rsp_n), {bus.rsp_rdata, bus.rsp_is_wr, bus.rsp_err},
              {mon_e.rdata, mon_e.is_wr, mon_e.err});
          if (mon_e.lat) chk($sformatf("latency%0d", rsp_n), cyc - mon_e.fcyc, LAT);
          rsp_n++;
        end
      end
    end
    stalled = reset_n && bus.rsp_valid && !bus.rsp_ready;
    held = {bus.rsp_rdata, bus.rsp_is_wr, bus.rsp_err};
  end
  task automatic issue(input logic we, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] er, input logic ee);
    int w = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    #1;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    stalls += w;
    if (bus.req_ready) exp_q.push_back('{er, we, ee, lat_on, cyc + 1});
    else chk("req_ready_timeout", 0, 1);
  endtask
  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain", exp_q.size(), 0);
  endtask
  task automatic wait_init();
    int n = 0;
    while (!bus.init_done && n < 1000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("init_cycles", n, EXP_INIT);
  endtask
  task automatic chk_reset_outputs();
    chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_is_wr,
                          bus.rsp_err, bus.init_done}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int acc;
    logic [31:0] d;
    reset_n = 1'b0;
    lat_on = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_be = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    reset_n = 1'b1;
    wait_init();
    chk("ready_after_init", bus.req_ready, 1);
    lat_on = 1'b1;
`ifdef MEM_INIT_CLEAR_EN
    issue(1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b0);
`endif
    issue(1'b1, 8'h05, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    issue(1'b1, 8'h05, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0);
    issue(1'b0, 8'h05, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0);
    idle();
    drain();
    issue(1'b1, 8'hC7, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    issue(1'b1, 8'hC8, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    issue(1'b0, 8'hC8, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1'b1, 8'hC7, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    issue(1'b0, 8'hC7, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    issue(1'b0, 8'hFF, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1'b1, 8'hC7, 32'h00CC_0000, 4'b0100, 32'h0, 1'b0);
    issue(1'b0, 8'hC7, 32'h0, 4'h0, 32'h12CC_5678, 1'b0);
    idle();
    drain();
    for (int k = 0; k < 4; k++) issue(1'b1, 8'h20 + 8'(k), tbl[k], 4'hF, 32'h0, 1'b0);
    idle();
    drain();
    lat_on = 1'b0;
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we = 1'b0;
      bus.req_addr = 8'h20 + 8'(acc & 3);
      #1;
      if (bus.req_ready) begin
        exp_q.push_back('{tbl[acc & 3], 1'b0, 1'b0, 1'b0, 0});
        acc++;
      end
    end
    chk("ready_low_when_full", bus.req_ready, 0);
    chk("accept_count", acc, RD);
    idle();
    repeat (3) @(negedge clk);
    bus.rsp_ready = 1'b1;
    drain();
    lat_on = 1'b1;
    stalls = 0;
    for (int i = 0; i < 500; i++) begin
      d = {16'(i), 16'hC0DE ^ 16'(i)};
      issue(1'b1, 8'(i % DEPTH), d, 4'hF, 32'h0, 1'b0);
      issue(1'b0, 8'(i % DEPTH), 32'h0, 4'h0, d, 1'b0);
    end
    idle();
    drain();
    chk("stream_stalls", stalls, 0);
    lat_on = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) issue(1'b0, 8'h20 + 8'(k), 32'h0, 4'h0, tbl[k], 1'b0);
    idle();
    repeat (4) @(negedge clk);
    chk("pending_before_reset", {bus.rsp_valid, bus.req_ready}, 2'b11);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    wait_init();
    repeat (10) @(negedge clk);
    chk("no_stale_rsp", bus.rsp_valid, 0);
    lat_on = 1'b1;
    issue(1'b1, 8'h40, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 8'h40, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    idle();
    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_ctrl_pipe.md
Name: mem_ctrl_pipe

Overview:
Parametrised single-port synchronous memory with a valid/ready request channel and an ordered, back-pressurable response channel. Adds byte-enable writes, a configurable read latency, and an error response for out-of-range addresses. A post-reset clear sequencer is optional. It is the successor to the fixed-size wr/rd memory and is used as the slave model/RAM behind bus masters in the memory test environment.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, request address width.
MEM_DEPTH, 256, number of words; must be ≤ 2**ADDR_WIDTH. Addresses ≥ MEM_DEPTH are out of range.
READ_LATENCY, 2, cycles from request acceptance to earliest rsp_valid; legal range 1..4.
RSP_DEPTH, 4, response FIFO entries; must be ≥ READ_LATENCY.

Ports:
clk  input  1  clock, all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  request can be accepted this cycle.
req_we  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  word address.
req_wdata  input  DATA_WIDTH  write data.
req_be  input  DATA_WIDTH/8  byte enables for writes.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
rsp_is_wr  output  1  response belongs to a write.
rsp_err  output  1  address was out of range.
init_done  output  1  memory is ready for traffic.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_is_wr=0, rsp_err=0, init_done=0.
  - Latency pipe cleared, FIFO emptied, in-flight count cleared, FSM→INIT.
- Reset asserted mid-operation: all in-flight and queued responses are discarded. Memory contents are not preserved.
- FSM states INIT → RUN.
  - INIT: see Optional Feature. Without the feature, INIT lasts exactly one cycle after reset release.
  - RUN: init_done=1. The FSM stays in RUN until reset.
- Request acceptance:
  - fire = req_valid & req_ready.
  - req_ready = (state==RUN) & (inflight + fifo_count < RSP_DEPTH).
  - req_ready does not depend combinationally on req_valid.
- Write on fire:
  - In range: for each byte b with req_be[b]=1, mem[addr][8b+7:8b] ← req_wdata byte b at the same edge.
  - req_be=0 is a legal no-op and still produces a response with rsp_err=0.
  - Out of range: no write; response has rsp_err=1.
- Read on fire:
  - In range: mem[addr] is sampled at the fire edge. A read accepted the cycle after a write to the same address returns the new data.
  - Out of range: rsp_rdata=0, rsp_err=1.
- Latency:
  - Each accepted request travels a READ_LATENCY-stage shift pipe, then enters the response FIFO.
  - With an empty FIFO and rsp_ready=1, rsp_valid rises exactly READ_LATENCY cycles after the fire edge.
  - One response is produced per request, strictly in acceptance order; reads and writes are never reordered.
- Response handshake:
  - rsp_valid/rsp_rdata/rsp_is_wr/rsp_err hold stable while rsp_valid=1 & rsp_ready=0.
  - An entry pops on rsp_valid & rsp_ready.
  - rsp_rdata=0 whenever rsp_valid=0; it is never high-Z.
- Credit rules:
  - inflight +1 on fire; −1 when a pipe entry enters the FIFO.
  - Simultaneous fire and pipe exit leave inflight unchanged.
  - Simultaneous FIFO push and pop leave fifo_count unchanged.
  - The FIFO can never overflow; an overflow would be a design error, flagged by an assertion.
- Full throughput: one request per cycle sustained while rsp_ready=1.

Optional Feature:
MEM_INIT_CLEAR_EN
- Defined:
  - After reset release, INIT sweeps addresses 0..MEM_DEPTH−1, writing 0 at one word per clock.
  - req_ready=0 throughout the sweep; init_done rises the cycle after the last word is cleared (MEM_DEPTH+1 cycles after reset release).
- Undefined:
  - No sweep; contents after reset are unknown (X in simulation).
  - init_done rises one cycle after reset release.

Decomposition:
- Package mem_ctrl_pkg holds:
  - typedef enum {INIT, RUN} state_t;
  - a packed struct rsp_t {rdata, is_wr, err};
  - a function for range checking.
- Sub-module mem_rsp_fifo: parametrised synchronous FIFO of rsp_t with depth RSP_DEPTH, count output, and async active-low reset.

Test Plan:
- Reset then idle, MEM_INIT_CLEAR_EN defined, MEM_DEPTH=256 → init_done=1 at cycle 257 after release. A read of addr 0x10 returns 0 with rsp_err=0.
- Write 0xDEADBEEF to 0x05 (be=4'hF), then write 0x000000AA with be=4'b0001, then read 0x05 → responses in order {wr,0}, {wr,0}, {rd,0xDEADBEAA}. The read response arrives exactly READ_LATENCY cycles after its acceptance.
- MEM_DEPTH=200, write to 0xC8, then read 0xC8 → both responses have rsp_err=1 and rdata=0. A later read of 0xC7 is unaffected.
- rsp_ready=0 held while issuing reads back-to-back → req_ready drops after exactly RSP_DEPTH acceptances. Releasing rsp_ready drains 4 responses in order with no loss or duplication.
- Continuous alternating write/read stream over 1000 cycles with rsp_ready=1 → one acceptance per cycle, scoreboard match.
- Assert reset_n=0 with 3 responses pending → all outputs return to reset values within the same cycle, and no stale responses appear after release.
